// File: rtl/osc_sup_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | osc_sup_pkg - shared types and helpers for osc_clk_supervisor      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package osc_sup_pkg;

  typedef enum logic [2:0] {
    RC_RUN   = 3'd0,
    GATE_OFF = 3'd1,
    SWITCH   = 3'd2,
    GATE_ON  = 3'd3,
    XTL_RUN  = 3'd4
  } sup_state_e;

  localparam logic SEL_RC  = 1'b0;
  localparam logic SEL_XTL = 1'b1;

  function automatic logic in_range(input logic [31:0] cnt,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/osc_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | osc_sync_edge - 2-flop synchroniser with both-edge pulse detector  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module osc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_pulse = sync_q ^ prev_q;

endmodule
`default_nettype wire

// File: rtl/osc_clk_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | osc_clk_supervisor - crystal health monitor and glitch-safe RC/XTL |
// | clock-select sequencer.                                  Rev 1.0   |
// +--------------------------------------------------------------------+
module osc_clk_supervisor
  import osc_sup_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int EXP_MIN       = 240,
  parameter int EXP_MAX       = 272,
  parameter int GOOD_WINDOWS  = 4,
  parameter int GATE_CYCLES   = 8,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             XTL_TOGGLE,
  input  logic             ENABLE,
  input  logic             FORCE_RC,
  output logic             CLK_SEL,
  output logic             CLK_GATE_EN,
  output logic             XTL_GOOD,
  output logic [CNT_W-1:0] EDGE_COUNT,
  output logic             SWITCH_EVT,
  output logic [7:0]       FAULT_CNT
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(GOOD_WINDOWS);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic edge_pulse;
  logic win_tc;
  logic verdict_ok;
  logic [CNT_W-1:0] edge_total;

  sup_state_e        state_q, state_d;
  logic              target_q, target_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              xtl_good_q, xtl_good_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;
  logic              clk_sel_q, clk_sel_d;
  logic              gate_en_q, gate_en_d;
  logic              switch_evt_q, switch_evt_d;

  osc_sync_edge u_sync (
    .clk        (CLK),
    .rst        (RESET),
    .async_in   (XTL_TOGGLE),
    .edge_pulse (edge_pulse)
  );

  // The closing window includes an edge seen on its own terminal cycle.
  assign win_tc     = (win_q == WIN_LAST);
  assign edge_total = (edge_cnt_q == {CNT_W{1'b1}}) ? edge_cnt_q
                                                    : edge_cnt_q + CNT_W'(edge_pulse);
  assign verdict_ok = in_range(32'(edge_total), 32'(EXP_MIN), 32'(EXP_MAX));

  always_comb begin
    win_d        = win_tc ? '0 : win_q + 1'b1;
    edge_cnt_d   = win_tc ? '0 : edge_total;
    edge_count_d = win_tc ? edge_total : edge_count_q;
    xtl_good_d   = win_tc ? verdict_ok : xtl_good_q;
    good_cnt_d   = good_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    state_d      = state_q;
    target_d     = target_q;
    gate_cnt_d   = gate_cnt_q;
    clk_sel_d    = clk_sel_q;
    gate_en_d    = gate_en_q;
    switch_evt_d = 1'b0;

    if (win_tc) begin
      if (verdict_ok) begin
        if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
      end else begin
        good_cnt_d = '0;
        if (clk_sel_q == SEL_XTL && fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 1'b1;
      end
    end

    case (state_q)
      RC_RUN: begin
        if (ENABLE && !FORCE_RC && good_cnt_q == GOOD_MAX) begin
          state_d    = GATE_OFF;
          target_d   = SEL_XTL;
          gate_en_d  = 1'b0;
          gate_cnt_d = '0;
        end
      end
      XTL_RUN: begin
        // A stale bad verdict taken during the inbound sequence also ejects us here.
        if (!ENABLE || FORCE_RC || !xtl_good_q || (win_tc && !verdict_ok)) begin
          state_d    = GATE_OFF;
          target_d   = SEL_RC;
          gate_en_d  = 1'b0;
          gate_cnt_d = '0;
        end
      end
      GATE_OFF: begin
        if (gate_cnt_q == GATE_LAST) begin
          state_d      = SWITCH;
          clk_sel_d    = target_q;
          switch_evt_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      SWITCH: begin
        state_d    = GATE_ON;
        gate_cnt_d = '0;
        good_cnt_d = '0;
      end
      GATE_ON: begin
        if (gate_cnt_q == GATE_LAST) begin
          state_d   = (clk_sel_q == SEL_XTL) ? XTL_RUN : RC_RUN;
          gate_en_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      default: state_d = RC_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= RC_RUN;
      target_q     <= SEL_RC;
      gate_cnt_q   <= '0;
      win_q        <= '0;
      edge_cnt_q   <= '0;
      edge_count_q <= '0;
      xtl_good_q   <= 1'b0;
      good_cnt_q   <= '0;
      fault_cnt_q  <= '0;
      clk_sel_q    <= SEL_RC;
      gate_en_q    <= 1'b1;
      switch_evt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      gate_cnt_q   <= gate_cnt_d;
      win_q        <= win_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      xtl_good_q   <= xtl_good_d;
      good_cnt_q   <= good_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      clk_sel_q    <= clk_sel_d;
      gate_en_q    <= gate_en_d;
      switch_evt_q <= switch_evt_d;
    end
  end

  assign CLK_SEL     = clk_sel_q;
  assign CLK_GATE_EN = gate_en_q;
  assign XTL_GOOD    = xtl_good_q;
  assign EDGE_COUNT  = edge_count_q;
  assign SWITCH_EVT  = switch_evt_q;
  assign FAULT_CNT   = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_clk_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_osc_clk_supervisor - scoreboard bench for osc_clk_supervisor    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_osc_clk_supervisor;

  localparam int WIN   = 64;
  localparam int EMIN  = 14;
  localparam int EMAX  = 18;
  localparam int GOODW = 2;
  localparam int GATEC = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst, xtl, en, force_rc;
  logic sel, gate, good, evt;
  logic [CW-1:0] ecount;
  logic [7:0]    fcnt;

  always #5 clk = ~clk;

  osc_clk_supervisor #(
    .WINDOW_CYCLES (WIN),
    .EXP_MIN       (EMIN),
    .EXP_MAX       (EMAX),
    .GOOD_WINDOWS  (GOODW),
    .GATE_CYCLES   (GATEC),
    .CNT_W         (CW)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .XTL_TOGGLE  (xtl),
    .ENABLE      (en),
    .FORCE_RC    (force_rc),
    .CLK_SEL     (sel),
    .CLK_GATE_EN (gate),
    .XTL_GOOD    (good),
    .EDGE_COUNT  (ecount),
    .SWITCH_EVT  (evt),
    .FAULT_CNT   (fcnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // clock edges since reset release
  int mode     = 0;   // 0 idle, 1 toggle /4, 2 toggle /2, 3 good-good-bad pattern
  int acc      = 0;   // edges attributed to the window being filled
  int evt_seen = 0;
  int ev0;
  int unsigned exp_q[$];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // A toggle driven after edge m reaches the counter at edge m+3, so it
  // belongs to window (m+2)/WIN; the expectation is queued once that window's
  // last contributing toggle has been driven.
  task automatic step();
    logic tog;
    int unsigned e;
    int m = cyc;
    case (mode)
      1:       tog = (m % 4 == 0);
      2:       tog = (m % 2 == 0);
      3:       tog = (((m + 2) / WIN) % 3 != 2) && ((m % 4 == 0) || m == 61);
      default: tog = 1'b0;
    endcase
    if (tog) begin
      xtl = ~xtl;
      acc++;
    end
    if ((m + 2) % WIN == WIN - 1) begin
      exp_q.push_back(acc);
      acc = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (evt) evt_seen++;
    if (cyc % WIN == 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow @cyc %0d: got 0 entries expected 1", cyc);
      end else begin
        e = exp_q.pop_front();
        check_val("edge_count", ecount, e);
        check_val("xtl_good", good, (e >= EMIN && e <= EMAX));
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    xtl  = 1'b0;
    mode = 0;
    acc  = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_val("rst_clk_sel", sel, 0);
    check_val("rst_gate_en", gate, 1);
    check_val("rst_xtl_good", good, 0);
    check_val("rst_edge_count", ecount, 0);
    check_val("rst_switch_evt", evt, 0);
    check_val("rst_fault_cnt", fcnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Entered one edge before the gate is expected to drop.
  task automatic seq_check(input logic new_sel, input logic pulse_force);
    logic old_sel = ~new_sel;
    step();
    if (pulse_force) force_rc = 1'b0;
    check_val("gate_off", gate, 0);
    check_val("sel_hold", sel, old_sel);
    repeat (GATEC - 1) begin
      step();
      check_val("gate_off", gate, 0);
      check_val("sel_hold", sel, old_sel);
    end
    step();
    check_val("sel_switch", sel, new_sel);
    check_val("switch_evt", evt, 1);
    check_val("gate_off_sw", gate, 0);
    repeat (GATEC) begin
      step();
      check_val("evt_pulse_end", evt, 0);
      check_val("gate_off_post", gate, 0);
      check_val("sel_new", sel, new_sel);
    end
    step();
    check_val("gate_on", gate, 1);
    check_val("sel_final", sel, new_sel);
  endtask

  initial begin
    rst = 1'b1; xtl = 1'b0; en = 1'b1; force_rc = 1'b0;
    do_reset();

    // 16 edges per window; two good windows then switch to crystal.
    mode = 1;
    run_to(2 * WIN);
    check_val("pre_switch_sel", sel, 0);
    check_val("pre_switch_gate", gate, 1);
    seq_check(1'b1, 1'b0);

    // Toggle stops: the straddling window holds 3 edges and is bad.
    mode = 0;
    run_to(3 * WIN - 1);
    seq_check(1'b0, 1'b0);
    check_val("fault_after_bad", fcnt, 1);
    check_val("xtl_good_bad", good, 0);
    run_to(4 * WIN);
    check_val("edge_count_idle", ecount, 0);
    check_val("fault_rc_idle", fcnt, 1);

    // Too many edges: never switches.
    mode = 2;
    ev0 = evt_seen;
    run_to(7 * WIN);
    check_val("fast_sel", sel, 0);
    check_val("fast_no_evt", evt_seen, ev0);
    check_val("fast_fault", fcnt, 1);

    // Back to crystal, then a one-cycle FORCE_RC.
    mode = 1;
    run_to(9 * WIN);
    seq_check(1'b1, 1'b0);
    force_rc = 1'b1;
    seq_check(1'b0, 1'b1);

    // Held FORCE_RC blocks the return despite good windows.
    force_rc = 1'b1;
    ev0 = evt_seen;
    run_to(12 * WIN);
    check_val("force_hold_sel", sel, 0);
    check_val("force_hold_no_evt", evt_seen, ev0);
    force_rc = 1'b0;
    seq_check(1'b1, 1'b0);

    // ENABLE drop starts GATE_OFF; reset lands mid-sequence.
    en = 1'b0;
    step();
    check_val("dis_gate_off", gate, 0);
    check_val("dis_sel", sel, 1);
    step();
    check_val("dis_gate_off2", gate, 0);
    do_reset();

    // GOOD_WINDOWS=2 means crystal is re-entered only after two good windows,
    // so each fault needs a good, good, bad triple. Window 0 has an edge on
    // its terminal cycle.
    en = 1'b1;
    mode = 3;
    run_to(WIN);
    check_val("terminal_edge", ecount, 17);
    run_to(3 * WIN);
    check_val("fault_first", fcnt, 1);
    run_to(254 * 3 * WIN);
    check_val("fault_254", fcnt, 254);
    run_to(255 * 3 * WIN);
    check_val("fault_255", fcnt, 255);
    run_to(260 * 3 * WIN);
    check_val("fault_sat", fcnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
